// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and data access.
// One outstanding transaction; data side has priority, bounded by a streak limit.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MTYPE_W    = 3,
  parameter int STREAK_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [31:0]        if_rdata,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [DATA_W-1:0]  dm_wdata,
  input  logic [MTYPE_W-1:0] dm_type,
  output logic               dm_gnt,
  output logic               dm_rvalid,
  output logic [DATA_W-1:0]  dm_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [MTYPE_W-1:0] mem_type,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam int STREAK_W = 4;
  // Fetches are issued as word, unsigned (funct3-style LWU encoding).
  localparam logic [MTYPE_W-1:0] IF_TYPE = MTYPE_W'(3'b110);

  state_t              state, state_next;
  logic [STREAK_W-1:0] streak;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    dm_gnt     = 1'b0;
    if_gnt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_req && (!if_req || streak < STREAK_W'(STREAK_MAX))) begin
          dm_gnt     = 1'b1;
          state_next = BUSY_D;
        end else if (if_req) begin
          if_gnt     = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Data-side grants only count against fetch while fetch is actually waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (!if_req || if_gnt) begin
      streak <= '0;
    end else if (dm_gnt && streak < STREAK_W'(STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

  // NOTE: the datapath registers are reset too, because every output must
  // read 0 during reset and a pending response must not survive it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_type  <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if (dm_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_type  <= dm_type;
      end else if (if_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_type  <= IF_TYPE;
      end
      // mem_* are left untouched while waiting so the memory sees a stable request.
      if (state == BUSY_I && mem_ready) begin
        mem_req   <= 1'b0;
        if_rvalid <= 1'b1;
        if_rdata  <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
      end
      if (state == BUSY_D && mem_ready) begin
        mem_req   <= 1'b0;
        dm_rvalid <= 1'b1;
        dm_rdata  <= mem_we ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [63:0] dm_addr, dm_wdata;
  logic [2:0]  dm_type;
  logic        dm_gnt, dm_rvalid;
  logic [63:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [2:0]  mem_type;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MTYPE_W(3), .STREAK_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_type(dm_type), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one pending transaction, the last one issued, any response owed
  // next cycle, and how many data grants fetch has watched go by.
  bit          m_busy, m_dm, m_if_rv, m_dm_rv;
  logic        m_we;
  logic [63:0] m_addr, m_wdata, m_dm_rdata;
  logic [2:0]  m_type;
  logic [31:0] m_if_rdata;
  int          m_streak;
  bit          e_dm_gnt, e_if_gnt;
  bit          s_if_gnt, s_dm_gnt;

  always @(negedge clk) begin
    if (!reset) begin
      m_busy = 0; m_dm = 0; m_if_rv = 0; m_dm_rv = 0; m_streak = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_type = '0;
      s_if_gnt = 0; s_dm_gnt = 0;
      check("rst_mem_req",   64'(mem_req),   64'd0);
      check("rst_mem_we",    64'(mem_we),    64'd0);
      check("rst_mem_addr",  mem_addr,       64'd0);
      check("rst_mem_wdata", mem_wdata,      64'd0);
      check("rst_mem_type",  64'(mem_type),  64'd0);
      check("rst_if_gnt",    64'(if_gnt),    64'd0);
      check("rst_dm_gnt",    64'(dm_gnt),    64'd0);
      check("rst_if_rvalid", 64'(if_rvalid), 64'd0);
      check("rst_dm_rvalid", 64'(dm_rvalid), 64'd0);
      check("rst_if_rdata",  64'(if_rdata),  64'd0);
      check("rst_dm_rdata",  dm_rdata,       64'd0);
    end else begin
      e_dm_gnt = !m_busy && dm_req && (!if_req || m_streak < SMAX);
      e_if_gnt = !m_busy && if_req && !e_dm_gnt;
      check("dm_gnt",    64'(dm_gnt),    64'(e_dm_gnt));
      check("if_gnt",    64'(if_gnt),    64'(e_if_gnt));
      check("mem_req",   64'(mem_req),   64'(m_busy));
      check("if_rvalid", 64'(if_rvalid), 64'(m_if_rv));
      check("dm_rvalid", 64'(dm_rvalid), 64'(m_dm_rv));
      if (m_busy) begin
        check("mem_we",    64'(mem_we),   64'(m_we));
        check("mem_addr",  mem_addr,      m_addr);
        check("mem_wdata", mem_wdata,     m_wdata);
        check("mem_type",  64'(mem_type), 64'(m_type));
      end
      if (m_if_rv) check("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
      if (m_dm_rv) check("dm_rdata", dm_rdata, m_dm_rdata);
      s_if_gnt = if_gnt;
      s_dm_gnt = dm_gnt;
      // Advance the model across the coming edge.
      m_if_rv = m_busy && !m_dm && mem_ready;
      m_dm_rv = m_busy &&  m_dm && mem_ready;
      if (m_if_rv) m_if_rdata = m_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
      if (m_dm_rv) m_dm_rdata = m_we ? 64'd0 : mem_rdata;
      if (m_busy) begin
        if (mem_ready) m_busy = 0;
      end else if (e_dm_gnt) begin
        m_busy = 1; m_dm = 1; m_we = dm_we; m_addr = dm_addr;
        m_wdata = dm_wdata; m_type = dm_type;
      end else if (e_if_gnt) begin
        m_busy = 1; m_dm = 0; m_we = 0; m_addr = if_addr;
        m_wdata = 64'd0; m_type = 3'b110;
      end
      if (!if_req || e_if_gnt) m_streak = 0;
      else if (e_dm_gnt)       m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] seq;
    int         idx;
    reset = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; dm_type = '0; mem_ready = 0; mem_rdata = '0;
    repeat (3) next_cycle();
    reset = 1;
    next_cycle();

    // Lone fetch from an upper-word address.
    if_req = 1; if_addr = 64'h104;
    @(negedge clk); check("t2_if_gnt", 64'(if_gnt), 64'd1);
    next_cycle();
    if_req = 0; mem_ready = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    check("t2_mem_req",  64'(mem_req),  64'd1);
    check("t2_mem_addr", mem_addr,      64'h104);
    check("t2_mem_type", 64'(mem_type), 64'd6);
    next_cycle();
    mem_ready = 0; mem_rdata = '0;
    @(negedge clk);
    check("t2_if_rvalid", 64'(if_rvalid), 64'd1);
    check("t2_if_rdata",  64'(if_rdata),  64'hAAAA_BBBB);
    check("t2_mem_req_clr", 64'(mem_req), 64'd0);
    next_cycle();

    // Simultaneous requests: data first, fetch in the next idle cycle.
    if_req = 1; if_addr = 64'h200;
    dm_req = 1; dm_we = 0; dm_addr = 64'h2000; dm_type = 3'd3;
    @(negedge clk);
    check("t3_dm_gnt", 64'(dm_gnt), 64'd1);
    check("t3_if_gnt", 64'(if_gnt), 64'd0);
    next_cycle();
    dm_req = 0; mem_ready = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    check("t3_mem_addr", mem_addr, 64'h2000);
    check("t3_busy_no_gnt", 64'(if_gnt), 64'd0);
    next_cycle();
    mem_ready = 0;
    @(negedge clk);
    check("t3_dm_rvalid", 64'(dm_rvalid), 64'd1);
    check("t3_dm_rdata",  dm_rdata,       64'h0123_4567_89AB_CDEF);
    check("t3_if_gnt2",   64'(if_gnt),    64'd1);
    next_cycle();
    if_req = 0; mem_ready = 1;
    next_cycle();
    mem_ready = 0;
    next_cycle();

    // Starvation limit: both held high, memory always ready.
    if_req = 1; if_addr = 64'h400; dm_req = 1; dm_we = 0; dm_addr = 64'h3000;
    mem_ready = 1; seq = '0; idx = 0;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      @(negedge clk);
      if (dm_gnt) begin seq[idx] = 1'b1; idx++; end
      else if (if_gnt) begin seq[idx] = 1'b0; idx++; end
      next_cycle();
    end
    check("t4_grant_count", 64'(idx), 64'd10);
    check("t4_grant_seq",   64'(seq), 64'(10'b01111_01111));
    if_req = 0; dm_req = 0;
    repeat (3) next_cycle();
    mem_ready = 0;
    next_cycle();

    // Store with three wait cycles.
    dm_req = 1; dm_we = 1; dm_addr = 64'h3008; dm_wdata = 64'h1122_3344_5566_7788; dm_type = 3'd3;
    @(negedge clk); check("t5_dm_gnt", 64'(dm_gnt), 64'd1);
    next_cycle();
    dm_req = 0; dm_we = 0; dm_wdata = '0; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_mem_req",   64'(mem_req),  64'd1);
      check("t5_mem_we",    64'(mem_we),   64'd1);
      check("t5_mem_addr",  mem_addr,      64'h3008);
      check("t5_mem_wdata", mem_wdata,     64'h1122_3344_5566_7788);
      check("t5_mem_type",  64'(mem_type), 64'd3);
      check("t5_no_rvalid", 64'(dm_rvalid), 64'd0);
      next_cycle();
      mem_ready = (i == 2);
    end
    @(negedge clk);
    check("t5_dm_rvalid", 64'(dm_rvalid), 64'd1);
    check("t5_dm_rdata",  dm_rdata,       64'd0);
    next_cycle();

    // mem_ready while idle is ignored.
    mem_ready = 1; mem_rdata = 64'h5555_6666_7777_8888;
    next_cycle();
    mem_ready = 0;
    @(negedge clk);
    check("t6_if_rvalid", 64'(if_rvalid), 64'd0);
    check("t6_dm_rvalid", 64'(dm_rvalid), 64'd0);
    check("t6_mem_req",   64'(mem_req),   64'd0);
    next_cycle();

    // Reset in the middle of a data transaction.
    dm_req = 1; dm_we = 0; dm_addr = 64'h4000; dm_type = 3'd3;
    next_cycle();
    dm_req = 0;
    check("t1_mem_req_before", 64'(mem_req), 64'd1);
    #2 reset = 0;
    #1 check("t1_mem_req_async", 64'(mem_req), 64'd0);
    next_cycle();
    reset = 1; mem_ready = 1; mem_rdata = 64'h9999_0000_9999_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_no_dm_rvalid", 64'(dm_rvalid), 64'd0);
      check("t1_idle_mem_req", 64'(mem_req),   64'd0);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if (s_if_gnt || !if_req) begin
        if_req  = ($urandom_range(0, 2) == 0);
        if_addr = {$urandom, $urandom} & ~64'h3;
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 0;
      end
      if (s_dm_gnt || !dm_req) begin
        dm_req   = ($urandom_range(0, 1) == 0);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_addr  = {$urandom, $urandom};
        dm_wdata = {$urandom, $urandom};
        dm_type  = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 15) == 0) begin
        dm_req = 0;
      end
      mem_ready = $urandom_range(0, 1) == 1;
      mem_rdata = {$urandom, $urandom};
      next_cycle();
    end
    if_req = 0; dm_req = 0; mem_ready = 1;
    repeat (4) next_cycle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
